register_file: RTL and testbench
================================

# register_file

Architectural register file for the single-cycle CPU, sitting directly upstream of the ALU. It holds 32 general-purpose 32-bit registers and drives the ALU's two register operands (A and B) combinationally from instruction fields rs/rt. It also owns the write-back path: destination selection (rt / rd / $31), source selection (ALU result / data memory / PC+4), and the clocked register write.

## Interface
- `NREG`, default 32: register count; address width is log2(NREG) = 5.
- `DW`, default 32: data width.
- `BYPASS`, default 1:
  - 1: a read of the register being written this cycle returns the write data.
  - 0: a read returns the stored value.
- `CLK` input 1: single clock; all state updates on its rising edge.
- `RST` input 1: asynchronous, active-low reset; clears all registers.
- `RegWre` input 1: write enable from the CU.
- `RegDst` input 2: destination select. 00 = rt, 01 = rd, 10 = $31, 11 = reserved (no write).
- `DBDataSrc` input 2: write-data select. 00 = ALU result, 01 = memory data, 10 = PC+4, 11 = reserved (selects zero).
- `rs`, `rt`, `rd` input 5: instruction register fields.
- `ALUResult` input 32: ALU result.
- `MemData` input 32: data memory read data.
- `PC4` input 32: PC+4.
- `DbgAddr` input 5: debug read address.
- `ReadData1` output 32: value of register[rs]; feeds ALU input A.
- `ReadData2` output 32: value of register[rt]; feeds ALU input B and the memory store data.
- `WriteReg` output 5: resolved destination address (for trace and debug).
- `WriteData` output 32: resolved write-back data.
- `DbgData` output 32: value of register[DbgAddr]; never bypassed.

## Operation
- **Storage**
  - `NREG` × `DW` flops.
  - Register 0 reads as 0 at all times, and writes to it are discarded.
- **Destination mux**
  - `WriteReg` = rt, rd or 31 per `RegDst`.
  - `RegDst` = 11 forces the write to be suppressed, even when `RegWre` = 1.
- **Data mux**
  - `WriteData` = `ALUResult`, `MemData` or `PC4` per `DBDataSrc`.
  - Code 11 yields 0.
- **Write condition**
  - A write occurs only when `RegWre` = 1, `RegDst` ≠ 11 and `WriteReg` ≠ 0.
  - On the rising edge, register[`WriteReg`] ← `WriteData`.
- **Reads**
  - Both read ports and the debug port are purely combinational, with no latency.
  - When `BYPASS` = 1, the write condition holds, and rs (or rt) equals `WriteReg`, the port outputs `WriteData` instead of the stored value.
  - Register 0 is never bypassed.
- **Read/write collisions**
  - rs = rt = `WriteReg`: both ports behave identically.
  - A simultaneous read and write of the same register without bypass returns the old value until the edge.
- **No other state.** There is no FSM. The only state is the register array.

## Timing
- **Reset**
  - While `RST` = 0, all registers are 0 immediately, with no dependence on `CLK`.
  - As a result, `ReadData1`, `ReadData2` and `DbgData` all read 0.
  - `WriteReg` and `WriteData` are combinational and follow their inputs even during reset.
  - No write takes effect while `RST` is low, including a `CLK` edge that coincides with reset assertion.
  - After `RST` deasserts, the first rising edge may perform a write.
- **Write latency**
  - Data presented in cycle N is stored at the edge ending cycle N.
  - Without bypass, the stored value is visible on the read ports from cycle N+1.
  - With bypass, it is visible in cycle N.
- **Read path.** Combinational from rs/rt/`DbgAddr` to the outputs. It must fit, together with the downstream ALU, in one clock period.
- **Reset mid-operation.** Any in-flight write is lost, and the register array returns to all-zero.

## Structure
- The shared package `cpu_pkg` holds:
  - the `RegDst` encodings: REGDST_RT, REGDST_RD, REGDST_RA, REGDST_NONE;
  - the `DBDataSrc` encodings: WB_ALU, WB_MEM, WB_PC4, WB_ZERO;
  - the `REG_RA` = 31 constant.

  The CU uses the same package.
- One sub-module, `wb_select`. It is purely combinational and contains both the destination mux and the data mux, and it outputs `WriteReg`, `WriteData` and a `WriteEn` qualifier.
- `register_file` instantiates `wb_select` and contains the array, the reads and the bypass logic.

## Test plan
- **Reset.** Write 0x12345678 to $5, then assert `RST` = 0 asynchronously between edges → `DbgData` for $5 is 0 immediately. No write occurs on edges while `RST` is held low.
- **R-type write.**
  - Stimulus: `RegWre` = 1, `RegDst` = 01, rd = 9, `DBDataSrc` = 00, `ALUResult` = 0xDEADBEEF.
  - After the edge, rs = 9 → `ReadData1` = 0xDEADBEEF.
- **$0 protection.** Stimulus: `RegDst` = 00, rt = 0, `RegWre` = 1, `MemData` = 0xFFFFFFFF → after the edge, `ReadData2` with rt = 0 reads 0.
- **jal link.** Stimulus: `RegDst` = 10, `DBDataSrc` = 10, `PC4` = 0x00000044 → `WriteReg` = 31; after the edge, `DbgData`(31) = 0x44.
- **Bypass.** With `BYPASS` = 1, write rd = 3 with 0xA5A5A5A5 while rs = rt = 3 → both ports show 0xA5A5A5A5 in the same cycle. With `BYPASS` = 0, both ports show the old value until the edge.
- **Reserved codes.** `RegDst` = 11 with `RegWre` = 1 → no register changes. `DBDataSrc` = 11 → `WriteData` = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Encodings shared by the control unit and the register file write-back path.
package cpu_pkg;

    typedef enum logic [1:0] {
        REGDST_RT   = 2'b00,
        REGDST_RD   = 2'b01,
        REGDST_RA   = 2'b10,
        REGDST_NONE = 2'b11
    } regdst_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC4  = 2'b10,
        WB_ZERO = 2'b11
    } wbsrc_e;

    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/register_file_if.sv
// Operand-read / write-back bus between the control path and the register file.
interface register_file_if
    import cpu_pkg::*;
#(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
);
    logic          RegWre;
    regdst_e       RegDst;
    wbsrc_e        DBDataSrc;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [DW-1:0] ALUResult;
    logic [DW-1:0] MemData;
    logic [DW-1:0] PC4;
    logic [AW-1:0] DbgAddr;
    logic [DW-1:0] ReadData1;
    logic [DW-1:0] ReadData2;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WriteData;
    logic [DW-1:0] DbgData;

    modport master (
        output RegWre, RegDst, DBDataSrc, rs, rt, rd, ALUResult, MemData, PC4, DbgAddr,
        input  ReadData1, ReadData2, WriteReg, WriteData, DbgData
    );

    modport slave (
        input  RegWre, RegDst, DBDataSrc, rs, rt, rd, ALUResult, MemData, PC4, DbgAddr,
        output ReadData1, ReadData2, WriteReg, WriteData, DbgData
    );

endinterface

// File: rtl/register_file_wb_select.sv
// Write-back destination and data selection, plus the write qualifier.
module wb_select
    import cpu_pkg::*;
#(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
) (
    input  logic          RegWre,
    input  regdst_e       RegDst,
    input  wbsrc_e        DBDataSrc,
    input  logic [AW-1:0] rt,
    input  logic [AW-1:0] rd,
    input  logic [DW-1:0] ALUResult,
    input  logic [DW-1:0] MemData,
    input  logic [DW-1:0] PC4,
    output logic [AW-1:0] WriteReg,
    output logic [DW-1:0] WriteData,
    output logic          WriteEn
);

    always_comb begin
        WriteReg = '0;
        case (RegDst)
            REGDST_RT: WriteReg = rt;
            REGDST_RD: WriteReg = rd;
            REGDST_RA: WriteReg = AW'(REG_RA);
            default:   WriteReg = '0;
        endcase
    end

    always_comb begin
        WriteData = '0;
        case (DBDataSrc)
            WB_ALU:  WriteData = ALUResult;
            WB_MEM:  WriteData = MemData;
            WB_PC4:  WriteData = PC4;
            default: WriteData = '0;
        endcase
    end

    // $0 is excluded here so the array and the bypass never see a write to it.
    assign WriteEn = RegWre && (RegDst != REGDST_NONE) && (WriteReg != '0);

endmodule

// File: rtl/register_file.sv
// 2-read / 1-write architectural register file with optional write-through bypass.
module register_file
    import cpu_pkg::*;
#(
    parameter int unsigned NREG   = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned BYPASS = 1
) (
    input  logic            CLK,
    input  logic            RST,
    register_file_if.slave  bus
);

    localparam int unsigned AW = $clog2(NREG);

    logic [DW-1:0] regs [NREG];
    logic [AW-1:0] write_reg;
    logic [DW-1:0] write_data;
    logic          write_en;

    wb_select #(.AW(AW), .DW(DW)) u_wb_select (
        .RegWre    (bus.RegWre),
        .RegDst    (bus.RegDst),
        .DBDataSrc (bus.DBDataSrc),
        .rt        (bus.rt),
        .rd        (bus.rd),
        .ALUResult (bus.ALUResult),
        .MemData   (bus.MemData),
        .PC4       (bus.PC4),
        .WriteReg  (write_reg),
        .WriteData (write_data),
        .WriteEn   (write_en)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            regs <= '{default: '0};
        end else if (write_en) begin
            regs[write_reg] <= write_data;
        end
    end

    // Bypass is gated by RST so every read port shows zero throughout reset.
    function automatic logic [DW-1:0] port_read(input logic [AW-1:0] addr, input logic allow_bypass);
        if (addr == '0) return '0;
        if (allow_bypass && (BYPASS != 0) && RST && write_en && (addr == write_reg)) return write_data;
        return regs[addr];
    endfunction

    always_comb begin
        bus.ReadData1 = port_read(bus.rs, 1'b1);
        bus.ReadData2 = port_read(bus.rt, 1'b1);
        bus.DbgData   = port_read(bus.DbgAddr, 1'b0);
    end

    assign bus.WriteReg  = write_reg;
    assign bus.WriteData = write_data;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: bypassing and non-bypassing instances against one array model.
module tb_register_file;
    import cpu_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    register_file_if #(.AW(5), .DW(32)) bus1 ();
    register_file_if #(.AW(5), .DW(32)) bus0 ();

    assign bus0.RegWre    = bus1.RegWre;
    assign bus0.RegDst    = bus1.RegDst;
    assign bus0.DBDataSrc = bus1.DBDataSrc;
    assign bus0.rs        = bus1.rs;
    assign bus0.rt        = bus1.rt;
    assign bus0.rd        = bus1.rd;
    assign bus0.ALUResult = bus1.ALUResult;
    assign bus0.MemData   = bus1.MemData;
    assign bus0.PC4       = bus1.PC4;
    assign bus0.DbgAddr   = bus1.DbgAddr;

    register_file #(.NREG(32), .DW(32), .BYPASS(1)) dut_byp (.CLK(CLK), .RST(RST), .bus(bus1));
    register_file #(.NREG(32), .DW(32), .BYPASS(0)) dut_nob (.CLK(CLK), .RST(RST), .bus(bus0));

    logic [31:0] model [32];
    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          wre;
        regdst_e     dst;
        wbsrc_e      src;
        logic [4:0]  rt, rd;
        logic [31:0] alu, mem, pc4;
        logic [4:0]  exp_wreg;
        logic [31:0] exp_wdata;
        logic [4:0]  ck_rs, ck_rt, ck_dbg;
        logic [31:0] exp_rd1, exp_rd2, exp_dbg;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] m_dest();
        case (bus1.RegDst)
            REGDST_RT: return bus1.rt;
            REGDST_RD: return bus1.rd;
            REGDST_RA: return 5'd31;
            default:   return 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata();
        case (bus1.DBDataSrc)
            WB_ALU:  return bus1.ALUResult;
            WB_MEM:  return bus1.MemData;
            WB_PC4:  return bus1.PC4;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_wen();
        return bus1.RegWre && (bus1.RegDst != REGDST_NONE) && (m_dest() != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] addr, input bit byp);
        if (!RST || addr == 5'd0) return 32'd0;
        if (byp && m_wen() && addr == m_dest()) return m_wdata();
        return model[addr];
    endfunction

    task automatic drive(input bit wre, input regdst_e dst, input wbsrc_e src,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                         input logic [4:0] dbg);
        bus1.RegWre = wre;  bus1.RegDst = dst;  bus1.DBDataSrc = src;
        bus1.rs = rs;  bus1.rt = rt;  bus1.rd = rd;
        bus1.ALUResult = alu;  bus1.MemData = mem;  bus1.PC4 = pc4;  bus1.DbgAddr = dbg;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".b1.rd1"}, bus1.ReadData1, m_read(bus1.rs, 1'b1));
        chk({tag, ".b1.rd2"}, bus1.ReadData2, m_read(bus1.rt, 1'b1));
        chk({tag, ".b1.dbg"}, bus1.DbgData, m_read(bus1.DbgAddr, 1'b0));
        chk({tag, ".b1.wdata"}, bus1.WriteData, m_wdata());
        chk({tag, ".b0.rd1"}, bus0.ReadData1, m_read(bus1.rs, 1'b0));
        chk({tag, ".b0.rd2"}, bus0.ReadData2, m_read(bus1.rt, 1'b0));
        chk({tag, ".b0.dbg"}, bus0.DbgData, m_read(bus1.DbgAddr, 1'b0));
        chk({tag, ".b0.wdata"}, bus0.WriteData, m_wdata());
        if (bus1.RegDst != REGDST_NONE) begin
            chk({tag, ".b1.wreg"}, {27'd0, bus1.WriteReg}, {27'd0, m_dest()});
            chk({tag, ".b0.wreg"}, {27'd0, bus0.WriteReg}, {27'd0, m_dest()});
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RST && m_wen()) model[m_dest()] = m_wdata();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        vecs[0] = '{1, REGDST_RD,   WB_ALU,  5'd2,  5'd9, 32'hDEADBEEF, 32'h0, 32'h0,   5'd9,  32'hDEADBEEF, 5'd9,  5'd0,  5'd9,  32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        vecs[1] = '{1, REGDST_RT,   WB_MEM,  5'd0,  5'd9, 32'h0, 32'hFFFFFFFF, 32'h0,   5'd0,  32'hFFFFFFFF, 5'd9,  5'd0,  5'd0,  32'hDEADBEEF, 32'h0, 32'h0};
        vecs[2] = '{1, REGDST_RA,   WB_PC4,  5'd4,  5'd5, 32'h1, 32'h2, 32'h44,         5'd31, 32'h44,       5'd31, 5'd9,  5'd31, 32'h44, 32'hDEADBEEF, 32'h44};
        vecs[3] = '{1, REGDST_NONE, WB_ALU,  5'd9,  5'd9, 32'h11111111, 32'h0, 32'h0,   5'd0,  32'h11111111, 5'd9,  5'd31, 5'd9,  32'hDEADBEEF, 32'h44, 32'hDEADBEEF};
        vecs[4] = '{1, REGDST_RD,   WB_MEM,  5'd0,  5'd7, 32'h0, 32'hCAFEF00D, 32'h0,   5'd7,  32'hCAFEF00D, 5'd7,  5'd9,  5'd7,  32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[5] = '{1, REGDST_RD,   WB_ZERO, 5'd0,  5'd7, 32'h55, 32'h66, 32'h77,       5'd7,  32'h0,        5'd7,  5'd7,  5'd7,  32'h0, 32'h0, 32'h0};
        vecs[6] = '{0, REGDST_RD,   WB_ALU,  5'd0,  5'd9, 32'h1234, 32'h0, 32'h0,       5'd9,  32'h1234,     5'd9,  5'd31, 5'd9,  32'hDEADBEEF, 32'h44, 32'hDEADBEEF};
        vecs[7] = '{1, REGDST_RT,   WB_PC4,  5'd31, 5'd0, 32'h0, 32'h0, 32'h100,        5'd31, 32'h100,      5'd31, 5'd31, 5'd31, 32'h100, 32'h100, 32'h100};

        // Reset held across an edge with a write pending: nothing may land.
        drive(1, REGDST_RD, WB_ALU, 5'd4, 5'd4, 5'd4, 32'h77777777, 32'h0, 32'h0, 5'd4);
        #2;
        check_all("reset");
        tick();
        check_all("reset_edge");
        #2;
        RST = 1'b1;
        #1;
        check_all("post_reset");
        tick();

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].wre, vecs[i].dst, vecs[i].src, 5'd0, vecs[i].rt, vecs[i].rd,
                  vecs[i].alu, vecs[i].mem, vecs[i].pc4, 5'd0);
            #3;
            chk($sformatf("vec%0d.wdata", i), bus1.WriteData, vecs[i].exp_wdata);
            if (vecs[i].dst != REGDST_NONE)
                chk($sformatf("vec%0d.wreg", i), {27'd0, bus1.WriteReg}, {27'd0, vecs[i].exp_wreg});
            tick();
            drive(0, REGDST_RT, WB_ALU, vecs[i].ck_rs, vecs[i].ck_rt, 5'd0, 32'h0, 32'h0, 32'h0, vecs[i].ck_dbg);
            #3;
            chk($sformatf("vec%0d.b1.rd1", i), bus1.ReadData1, vecs[i].exp_rd1);
            chk($sformatf("vec%0d.b1.rd2", i), bus1.ReadData2, vecs[i].exp_rd2);
            chk($sformatf("vec%0d.b1.dbg", i), bus1.DbgData, vecs[i].exp_dbg);
            chk($sformatf("vec%0d.b0.rd1", i), bus0.ReadData1, vecs[i].exp_rd1);
            chk($sformatf("vec%0d.b0.rd2", i), bus0.ReadData2, vecs[i].exp_rd2);
            tick();
        end

        drive(1, REGDST_RD, WB_ALU, 5'd0, 5'd0, 5'd3, 32'h0F0F0F0F, 32'h0, 32'h0, 5'd0);
        tick();
        drive(1, REGDST_RD, WB_ALU, 5'd3, 5'd3, 5'd3, 32'hA5A5A5A5, 32'h0, 32'h0, 5'd3);
        #3;
        chk("byp.b1.rd1", bus1.ReadData1, 32'hA5A5A5A5);
        chk("byp.b1.rd2", bus1.ReadData2, 32'hA5A5A5A5);
        chk("byp.b1.dbg", bus1.DbgData, 32'h0F0F0F0F);
        chk("byp.b0.rd1", bus0.ReadData1, 32'h0F0F0F0F);
        chk("byp.b0.rd2", bus0.ReadData2, 32'h0F0F0F0F);
        tick();
        drive(0, REGDST_RD, WB_ALU, 5'd3, 5'd3, 5'd3, 32'h0, 32'h0, 32'h0, 5'd3);
        #3;
        chk("byp_after.b0.rd1", bus0.ReadData1, 32'hA5A5A5A5);
        chk("byp_after.b0.rd2", bus0.ReadData2, 32'hA5A5A5A5);
        chk("byp_after.b1.dbg", bus1.DbgData, 32'hA5A5A5A5);
        tick();
        drive(1, REGDST_RT, WB_ALU, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0);
        #3;
        chk("byp_r0.b1.rd1", bus1.ReadData1, 32'h0);
        chk("byp_r0.b1.rd2", bus1.ReadData2, 32'h0);
        tick();

        // Asynchronous reset between edges clears $5 at once; edges under reset write nothing.
        drive(1, REGDST_RD, WB_ALU, 5'd0, 5'd0, 5'd5, 32'h12345678, 32'h0, 32'h0, 5'd5);
        tick();
        #2;
        chk("rst.pre.dbg5", bus1.DbgData, 32'h12345678);
        RST = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        #1;
        chk("rst.async.b1.dbg5", bus1.DbgData, 32'h0);
        chk("rst.async.b0.dbg5", bus0.DbgData, 32'h0);
        drive(1, REGDST_RD, WB_MEM, 5'd6, 5'd6, 5'd6, 32'h0, 32'h66666666, 32'h0, 5'd6);
        #1;
        check_all("rst.hold");
        tick();
        tick();
        chk("rst.hold.dbg6", bus1.DbgData, 32'h0);
        #2;
        RST = 1'b1;
        tick();
        drive(0, REGDST_RD, WB_ALU, 5'd6, 5'd5, 5'd0, 32'h0, 32'h0, 32'h0, 5'd6);
        #3;
        chk("rst.first_write.dbg6", bus0.DbgData, 32'h66666666);
        chk("rst.first_write.rd2", bus0.ReadData2, 32'h0);
        tick();

        for (int i = 0; i < 400; i++) begin
            logic [4:0] rd_r;
            rd_r = 5'($urandom_range(0, 31));
            drive(bit'($urandom_range(0, 3) != 0), regdst_e'($urandom_range(0, 3)), wbsrc_e'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? rd_r : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? rd_r : 5'($urandom_range(0, 31)),
                  rd_r, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
            #3;
            check_all($sformatf("rand%0d", i));
            if (i == 200) begin
                RST = 1'b0;
                for (int j = 0; j < 32; j++) model[j] = 32'd0;
                #1;
                check_all("rand_rst");
                tick();
                RST = 1'b1;
            end else begin
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
